// File: rtl/dma_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_xfer_ctrl_if
// Brief    : Read/write request-grant memory port bundle for the DMA engine.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_xfer_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_rvalid;
    logic [DATA_WIDTH-1:0] rd_rdata;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;
    logic                  wr_ack;

    modport master (
        output rd_req, rd_addr,
        input  rd_gnt, rd_rvalid, rd_rdata,
        output wr_req, wr_addr, wr_data,
        input  wr_gnt, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr,
        output rd_gnt, rd_rvalid, rd_rdata,
        input  wr_req, wr_addr, wr_data,
        output wr_gnt, wr_ack
    );
endinterface
`default_nettype wire

// File: rtl/dma_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_xfer_ctrl
// Brief    : Word-at-a-time DMA copy engine with a software-visible status word.
//            Optional handshake watchdog enabled by DMA_XFER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dma_xfer_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic [DATA_WIDTH-1:0] config_i,
    input  wire logic [DATA_WIDTH-1:0] length_i,
    input  wire logic [ADDR_WIDTH-1:0] source_addr_i,
    input  wire logic [ADDR_WIDTH-1:0] dest_addr_i,
    output logic      [DATA_WIDTH-1:0] state_o,
    dma_xfer_ctrl_if.master            mem
);

    localparam int                    c_WB         = DATA_WIDTH / 8;
    localparam int                    c_ALIGN_BITS = $clog2(c_WB);
    localparam logic [ADDR_WIDTH-1:0] c_WB_ADDR    = ADDR_WIDTH'(c_WB);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_fsm;
    state_t                w_next;
    logic                  r_start_q;
    logic                  w_start_pulse;
    logic                  w_busy;
    logic                  w_misalign;
    logic                  w_latch;
    logic                  w_capture;
    logic                  w_advance;
    logic                  w_clear;
    logic                  w_set_align;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [DATA_WIDTH-1:0] r_data;
    logic [7:0]            r_cnt;
    logic                  r_err_align;
    logic                  w_err_timeout;
    logic [DATA_WIDTH-1:0] w_state_word;
    logic [DATA_WIDTH-1:0] r_state_word;
    logic                  w_unused_bits;

    assign w_start_pulse = config_i[0] & ~r_start_q;
    assign w_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_misalign    = (|source_addr_i[c_ALIGN_BITS-1:0]) |
                           (|dest_addr_i[c_ALIGN_BITS-1:0]);

    always_comb begin
        w_next_fsm  = r_state;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_clear     = 1'b0;
        w_set_align = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_pulse) begin
                    w_latch = 1'b1;
                    if (w_misalign) begin
                        w_set_align = 1'b1;
                        w_next_fsm  = S_DONE;
                    end else if (length_i[7:0] == 8'd0) begin
                        w_next_fsm = S_DONE;
                    end else begin
                        w_next_fsm = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (mem.rd_gnt) w_next_fsm = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem.rd_rvalid) begin
                    w_capture  = 1'b1;
                    w_next_fsm = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (mem.wr_gnt) w_next_fsm = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (mem.wr_ack) begin
                    w_advance  = 1'b1;
                    w_next_fsm = (r_cnt == 8'd1) ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE: begin
                // START is deliberately not looked at here, even alongside CLR_DONE
                if (config_i[1]) begin
                    w_clear    = 1'b1;
                    w_next_fsm = S_IDLE;
                end
            end
            default: w_next_fsm = S_IDLE;
        endcase
    end

`ifdef DMA_XFER_TIMEOUT_EN
    localparam int                  c_WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_err_timeout;
    logic                w_wdog_fire;

    // Progress on a handshake wins over an expiry landing in the same cycle
    assign w_wdog_fire   = w_busy && (r_wdog == c_WDOG_LAST) && (w_next_fsm == r_state);
    assign w_next        = w_wdog_fire ? S_DONE : w_next_fsm;
    assign w_err_timeout = r_err_timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_wdog <= '0;
            end else if (w_busy) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_clear) begin
                r_err_timeout <= 1'b0;
            end else if (w_wdog_fire) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign w_unused_bits = ^{config_i[DATA_WIDTH-1:2], length_i[DATA_WIDTH-1:8]};
`else
    assign w_next        = w_next_fsm;
    assign w_err_timeout = 1'b0;
    assign w_unused_bits = ^{config_i[DATA_WIDTH-1:2], length_i[DATA_WIDTH-1:8],
                             (TIMEOUT_CYCLES > 0)};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_err_align <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_q <= config_i[0];
            if (w_latch) begin
                r_src <= source_addr_i;
                r_dst <= dest_addr_i;
                r_cnt <= w_misalign ? 8'd0 : length_i[7:0];
            end else if (w_advance) begin
                r_src <= r_src + c_WB_ADDR;
                r_dst <= r_dst + c_WB_ADDR;
                r_cnt <= r_cnt - 8'd1;
            end else if (w_clear) begin
                r_cnt <= '0;
            end
            if (w_capture) r_data <= mem.rd_rdata;
            if (w_clear) begin
                r_err_align <= 1'b0;
            end else if (w_set_align) begin
                r_err_align <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_word       = '0;
        w_state_word[0]    = w_busy;
        w_state_word[1]    = (r_state == S_DONE);
        w_state_word[2]    = r_err_align;
        w_state_word[3]    = w_err_timeout;
        w_state_word[15:8] = r_cnt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_word <= '0;
        end else begin
            r_state_word <= w_state_word;
        end
    end

    assign state_o     = r_state_word;
    assign mem.rd_req  = (r_state == S_RD_REQ);
    assign mem.rd_addr = r_src;
    assign mem.wr_req  = (r_state == S_WR_REQ);
    assign mem.wr_addr = r_dst;
    assign mem.wr_data = r_data;

endmodule
`default_nettype wire
